// File: rtl/clk_ratio_monitor.sv
// Measures period and high time of a synchronously divided clock in reference cycles,
// tracks lock against i_exp_ratio and flags stalls. Optional duty check: CLK_RATIO_MON_DUTY_CHECK_EN.
module clk_ratio_monitor #(
    parameter int LOCK_CNT = 4
) (
    input  logic       i_ref_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_div_clk,
    input  logic [4:0] i_exp_ratio,
    output logic [4:0] o_ratio,
    output logic [4:0] o_high_cnt,
    output logic       o_valid,
    output logic       o_locked,
    output logic       o_err,
    output logic       o_duty_err,
    output logic       o_stall
);

    typedef enum logic [1:0] {DISABLED, SEEK, MEASURE, STALL} state_t;

    state_t     state;
    logic       div_q;
    logic [4:0] cnt;
    logic [4:0] high;
    logic [4:0] exp_q;
    logic [3:0] match;

    logic       rise;
    logic       exp_ok;
    logic       exp_chg;
    logic       cap;
    logic [3:0] match_base;
    logic [3:0] match_inc;

    assign rise    = i_div_clk & ~div_q;
    assign exp_ok  = (i_exp_ratio >= 5'd2);
    assign exp_chg = (i_exp_ratio != exp_q);
    assign cap     = i_en & rise & (state == MEASURE);

    // A capture in the same cycle as an expected-ratio change counts from zero.
    assign match_base = exp_chg ? 4'd0 : match;
    assign match_inc  = (match_base == 4'd15) ? 4'd15 : match_base + 4'd1;

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= DISABLED;
            div_q      <= 1'b0;
            cnt        <= 5'd0;
            high       <= 5'd0;
            exp_q      <= 5'd0;
            match      <= 4'd0;
            o_ratio    <= 5'd0;
            o_high_cnt <= 5'd0;
            o_valid    <= 1'b0;
            o_locked   <= 1'b0;
            o_err      <= 1'b0;
            o_stall    <= 1'b0;
        end else begin
            div_q   <= i_div_clk;
            exp_q   <= i_exp_ratio;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            if (!i_en) begin
                state    <= DISABLED;
                cnt      <= 5'd0;
                high     <= 5'd0;
                match    <= 4'd0;
                o_locked <= 1'b0;
                o_stall  <= 1'b0;
            end else begin
                if (exp_chg || !exp_ok) begin
                    match    <= 4'd0;
                    o_locked <= 1'b0;
                end
                case (state)
                    DISABLED: state <= SEEK;
                    SEEK: begin
                        if (rise) begin
                            state <= MEASURE;
                            cnt   <= 5'd1;
                            high  <= 5'd1;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            o_ratio    <= cnt;
                            o_high_cnt <= high;
                            o_valid    <= 1'b1;
                            cnt        <= 5'd1;
                            high       <= 5'd1;
                            if (exp_ok) begin
                                if (cnt == i_exp_ratio) begin
                                    match    <= match_inc;
                                    o_locked <= (match_inc >= 4'(LOCK_CNT));
                                end else begin
                                    o_err    <= 1'b1;
                                    match    <= 4'd0;
                                    o_locked <= 1'b0;
                                end
                            end
                        end else if (cnt == 5'd31) begin
                            state    <= STALL;
                            o_stall  <= 1'b1;
                            o_locked <= 1'b0;
                            match    <= 4'd0;
                        end else begin
                            cnt <= cnt + 5'd1;
                            if (i_div_clk && high != 5'd31)
                                high <= high + 5'd1;
                        end
                    end
                    STALL: begin
                        match    <= 4'd0;
                        o_locked <= 1'b0;
                        // Restart cleanly; the stalled interval is never reported.
                        if (rise) begin
                            state   <= MEASURE;
                            cnt     <= 5'd1;
                            high    <= 5'd1;
                            o_stall <= 1'b0;
                        end
                    end
                    default: state <= DISABLED;
                endcase
            end
        end
    end

`ifdef CLK_RATIO_MON_DUTY_CHECK_EN
    logic [4:0] half_lo;
    logic [4:0] half_hi;
    logic       duty_bad;

    assign half_lo  = cnt >> 1;
    assign half_hi  = 5'((6'(cnt) + 6'd1) >> 1);
    assign duty_bad = (cnt >= 5'd2) && (high != half_lo) && (high != half_hi);

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst)
            o_duty_err <= 1'b0;
        else
            o_duty_err <= cap & duty_bad;
    end
`else
    assign o_duty_err = 1'b0;
`endif

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Directed bench for clk_ratio_monitor: expected captures are queued as periods are driven
// and checked against each o_valid; flag timing is checked inline.
module tb_clk_ratio_monitor;

    logic       i_ref_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_en = 1'b0;
    logic       i_div_clk = 1'b0;
    logic [4:0] i_exp_ratio = 5'd4;
    logic [4:0] o_ratio;
    logic [4:0] o_high_cnt;
    logic       o_valid;
    logic       o_locked;
    logic       o_err;
    logic       o_duty_err;
    logic       o_stall;

`ifdef CLK_RATIO_MON_DUTY_CHECK_EN
    localparam logic DUTY = 1'b1;
`else
    localparam logic DUTY = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] ratio;
        logic [4:0] high;
        logic       locked;
        logic       err;
        logic       duty;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    int   n0;

    clk_ratio_monitor #(.LOCK_CNT(4)) dut (
        .i_ref_clk  (i_ref_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_div_clk  (i_div_clk),
        .i_exp_ratio(i_exp_ratio),
        .o_ratio    (o_ratio),
        .o_high_cnt (o_high_cnt),
        .o_valid    (o_valid),
        .o_locked   (o_locked),
        .o_err      (o_err),
        .o_duty_err (o_duty_err),
        .o_stall    (o_stall)
    );

    always #5 i_ref_clk = ~i_ref_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [4:0] r, input logic [4:0] h, input logic l,
                        input logic e, input logic d);
        exp_t x;
        x.ratio = r; x.high = h; x.locked = l; x.err = e; x.duty = d;
        sb.push_back(x);
    endtask

    task automatic step(input logic d);
        @(posedge i_ref_clk); #1;
        i_div_clk = d;
    endtask

    // One divided-clock period; the expected ratio is updated the cycle after its rise.
    task automatic period(input int h, input int l, input logic [4:0] e);
        for (int i = 0; i < h + l; i++) begin
            @(posedge i_ref_clk); #1;
            i_div_clk = (i < h);
            if (i == 1) i_exp_ratio = e;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ratio"},  o_ratio, 0);
        chk({tag, "_high"},   o_high_cnt, 0);
        chk({tag, "_valid"},  o_valid, 0);
        chk({tag, "_locked"}, o_locked, 0);
        chk({tag, "_err"},    o_err, 0);
        chk({tag, "_stall"},  o_stall, 0);
    endtask

    always @(negedge i_ref_clk) begin
        if (o_valid === 1'b1) begin
            exp_t e;
            valid_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("ratio",    o_ratio, e.ratio);
                chk("high_cnt", o_high_cnt, e.high);
                chk("locked",   o_locked, e.locked);
                chk("err",      o_err, e.err);
                chk("duty_err", o_duty_err, e.duty);
            end
        end else if (!i_rst) begin
            chk("stray_pulse", {o_err, o_duty_err}, 0);
        end
    end

    initial begin
        #2 i_rst = 1'b1;
        #1 chk_idle("reset");
        i_en = 1'b1;
        @(posedge i_ref_clk); #1 i_rst = 1'b0;
        chk_idle("post_reset");
        step(0); step(0);

        // ratio 4, 2 high / 2 low
        for (int k = 0; k < 5; k++) begin
            push(4, 2, k >= 3, 0, 0);
            period(2, 2, 4);
        end

        // ratio 7, then a skewed 1/6 period
        for (int k = 0; k < 4; k++) begin
            push(7, 3, k == 3, 0, 0);
            period(3, 4, 7);
        end
        push(7, 1, 1, 0, DUTY); period(1, 6, 7);
        push(7, 3, 1, 0, 0);    period(3, 4, 7);

        // lock at 6, divider moves to 5, expectation follows
        for (int k = 0; k < 4; k++) begin
            push(6, 3, k == 3, 0, 0);
            period(3, 3, 6);
        end
        push(5, 3, 0, 1, 0); period(3, 2, 6);
        for (int k = 0; k < 4; k++) begin
            push(5, 3, k == 3, 0, 0);
            period(3, 2, 5);
        end

        // stall: one rise then held low for 40 cycles
        step(1);
        for (int k = 0; k < 31; k++) step(0);
        chk("stall_early",  o_stall, 0);
        chk("locked_held",  o_locked, 1);
        step(0);
        chk("stall_at_32",  o_stall, 1);
        chk("stall_unlock", o_locked, 0);
        for (int k = 0; k < 8; k++) step(0);
        chk("stall_hold", o_stall, 1);

        // restart at ratio 3
        i_exp_ratio = 5'd3;
        push(3, 2, 0, 0, 0);
        step(1);
        chk("stall_before_rise", o_stall, 1);
        step(1);
        chk("stall_cleared", o_stall, 0);
        step(0);
        for (int k = 0; k < 3; k++) begin
            push(3, 2, k == 2, 0, 0);
            period(2, 1, 3);
        end
        period(2, 1, 3);

        // enable drops on the same cycle as a rise
        @(posedge i_ref_clk); #1;
        i_en = 1'b0; i_div_clk = 1'b1;
        step(1);
        chk("dis_locked", o_locked, 0);
        chk("dis_stall",  o_stall, 0);
        chk("dis_valid",  o_valid, 0);
        for (int k = 0; k < 3; k++) period(1, 1, 3);
        chk("dis_ratio_hold", o_ratio, 3);
        chk("dis_high_hold",  o_high_cnt, 2);

        // re-enable, then reset mid-period
        @(posedge i_ref_clk); #1;
        i_en = 1'b1; i_div_clk = 1'b0;
        step(0);
        push(3, 2, 0, 0, 0); period(2, 1, 3);
        step(1); step(1); step(0);
        i_rst = 1'b1;
        #1 chk_idle("mid_reset");
        @(posedge i_ref_clk); #1;
        i_rst = 1'b0; i_exp_ratio = 5'd2; i_div_clk = 1'b0;
        step(0);

        // ratio 2, back to back
        push(2, 1, 0, 0, 0); period(1, 1, 2);
        n0 = valid_cnt;
        for (int k = 1; k < 5; k++) begin
            push(2, 1, k >= 3, 0, 0);
            period(1, 1, 2);
        end
        @(negedge i_ref_clk); #1;
        chk("ratio2_spacing", valid_cnt - n0, 4);

        // expected ratio below 2: compare suppressed
        push(2, 1, 0, 0, 0); period(1, 1, 1);
        push(2, 1, 0, 0, 0); period(1, 1, 1);
        step(1); step(0);
        @(posedge i_ref_clk); #1;
        i_en = 1'b0;
        for (int k = 0; k < 4; k++) step(0);
        chk("final_locked", o_locked, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
